// File: rtl/jt51_pkg.sv
// Shared JT51 definitions: timer register map, control-bit layout and busy timing.
package jt51_pkg;

    localparam logic [7:0] REG_VALA_HI = 8'h10;
    localparam logic [7:0] REG_VALA_LO = 8'h11;
    localparam logic [7:0] REG_VALB    = 8'h12;
    localparam logic [7:0] REG_CTRL    = 8'h14;

    localparam int CTRL_LOAD_A = 0;
    localparam int CTRL_LOAD_B = 1;
    localparam int CTRL_IRQ_A  = 2;
    localparam int CTRL_IRQ_B  = 3;
    localparam int CTRL_CLR_A  = 4;
    localparam int CTRL_CLR_B  = 5;
    localparam int CTRL_CSM    = 7;

    localparam int BUSY_CYCLES_DEF = 32;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_pair_t;

endpackage

// File: rtl/jt51_busy_cnt.sv
// Busy down-counter: loads on commit, counts cen ticks down, holds at zero.
module jt51_busy_cnt
    import jt51_pkg::*;
#(
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen_i,
    input  logic load_i,
    output logic nz_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = 8'(BUSY_CYCLES);
        else if (cen_i && cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign nz_o = (cnt_q != 8'd0);

endmodule

// File: rtl/jt51_timer_mmr.sv
// JT51 timer register file: CPU write capture, cen-paced commit and busy status.
module jt51_timer_mmr
    import jt51_pkg::*;
#(
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       csm,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       busy
);

    logic       wr_q;
    logic [7:0] addr_q, addr_d;
    logic       pend_q, pend_d;
    wr_pair_t   pair_q, pair_d;
    logic [9:0] vala_q, vala_d;
    logic [7:0] valb_q, valb_d;
    logic [4:0] ctrl_q, ctrl_d;
    logic       clra_d, clrb_d;
    logic       clra_q, clrb_q;
    logic [7:0] dout_q;
    logic       cnt_nz;
    logic       wr_now, wr_ev, commit;

    assign wr_now = !cs_n && !wr_n;
    assign wr_ev  = wr_now && !wr_q;
    assign commit = cen && pend_q;

    always_comb begin
        addr_d = addr_q;
        pend_d = pend_q;
        pair_d = pair_q;
        vala_d = vala_q;
        valb_d = valb_q;
        ctrl_d = ctrl_q;
        clra_d = 1'b0;
        clrb_d = 1'b0;
        if (wr_ev && !a0)
            addr_d = din;
        if (commit) begin
            pend_d = 1'b0;
            case (pair_q.addr)
                REG_VALA_HI: vala_d[9:2] = pair_q.data;
                REG_VALA_LO: vala_d[1:0] = pair_q.data[1:0];
                REG_VALB:    valb_d      = pair_q.data;
                REG_CTRL: begin
                    ctrl_d = {pair_q.data[CTRL_CSM],
                              pair_q.data[CTRL_IRQ_B],
                              pair_q.data[CTRL_IRQ_A],
                              pair_q.data[CTRL_LOAD_B],
                              pair_q.data[CTRL_LOAD_A]};
                    clra_d = pair_q.data[CTRL_CLR_A];
                    clrb_d = pair_q.data[CTRL_CLR_B];
                end
                default: ;
            endcase
        end
        // A data write landing on the commit clk queues behind the older pair
        if (wr_ev && a0) begin
            pend_d = 1'b1;
            pair_d = '{addr: addr_q, data: din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            addr_q <= 8'd0;
            pend_q <= 1'b0;
            pair_q <= '0;
            vala_q <= 10'd0;
            valb_q <= 8'd0;
            ctrl_q <= 5'd0;
            clra_q <= 1'b0;
            clrb_q <= 1'b0;
            dout_q <= 8'd0;
        end else begin
            wr_q   <= wr_now;
            addr_q <= addr_d;
            pend_q <= pend_d;
            pair_q <= pair_d;
            vala_q <= vala_d;
            valb_q <= valb_d;
            ctrl_q <= ctrl_d;
            clra_q <= clra_d;
            clrb_q <= clrb_d;
            dout_q <= {busy, 5'b0, flag_B, flag_A};
        end
    end

    jt51_busy_cnt #(
        .BUSY_CYCLES (BUSY_CYCLES)
    ) u_busy_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (cen),
        .load_i (commit),
        .nz_o   (cnt_nz)
    );

    assign busy         = pend_q || cnt_nz;
    assign dout         = dout_q;
    assign value_A      = vala_q;
    assign value_B      = valb_q;
    assign load_A       = ctrl_q[0];
    assign load_B       = ctrl_q[1];
    assign enable_irq_A = ctrl_q[2];
    assign enable_irq_B = ctrl_q[3];
    assign csm          = ctrl_q[4];
    assign clr_flag_A   = clra_q;
    assign clr_flag_B   = clrb_q;

endmodule

// File: tb/tb_jt51_timer_mmr.sv
// Directed self-checking bench for jt51_timer_mmr.
module tb_jt51_timer_mmr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, enable_irq_A, enable_irq_B, csm;
    logic       clr_flag_A, clr_flag_B, busy;

    int n_cmp = 0;
    int n_bad = 0;

    jt51_timer_mmr #(.BUSY_CYCLES(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .a0           (a0),
        .din          (din),
        .dout         (dout),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .csm          (csm),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] all_out();
        return {dout, value_A, value_B, load_A, load_B, enable_irq_A,
                enable_irq_B, csm, clr_flag_A, clr_flag_B, busy};
    endfunction

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    // Counts negedges with busy high, starting at the current one.
    task automatic run_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out() !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", all_out());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_value_a;
        int n;
        wr(1'b0, 8'h10);
        wr(1'b1, 8'hAB);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_pending got=%b want=1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (value_A !== 10'h2AC) begin
            n_bad++;
            $display("FAIL value_A_hi got=%h want=2ac", value_A);
        end
        run_busy(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL busy_len_1 got=%0d want=32", n);
        end
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h03);
        @(negedge clk);
        n_cmp++;
        if (value_A !== 10'h2AF) begin
            n_bad++;
            $display("FAIL value_A_lo got=%h want=2af", value_A);
        end
        run_busy(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL busy_len_2 got=%0d want=32", n);
        end
    endtask

    task automatic test_ctrl;
        int n;
        logic [6:0] v;
        wr(1'b0, 8'h14);
        wr(1'b1, 8'h35);
        @(negedge clk);
        v = {load_A, load_B, enable_irq_A, enable_irq_B, csm,
             clr_flag_A, clr_flag_B};
        n_cmp++;
        if (v !== 7'b1010011) begin
            n_bad++;
            $display("FAIL ctrl_commit got=%b want=1010011", v);
        end
        @(negedge clk);
        v = {load_A, load_B, enable_irq_A, enable_irq_B, csm,
             clr_flag_A, clr_flag_B};
        n_cmp++;
        if (v !== 7'b1010000) begin
            n_bad++;
            $display("FAIL ctrl_pulse_end got=%b want=1010000", v);
        end
        run_busy(n);
    endtask

    task automatic test_cen_low;
        int n;
        cen = 1'b0;
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, value_B} !== {1'b1, 8'h00}) begin
                n_bad++;
                $display("FAIL cen_low_hold i=%0d got=%b/%h want=1/00",
                         i, busy, value_B);
            end
        end
        cen = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (value_B !== 8'h5A) begin
            n_bad++;
            $display("FAIL cen_low_commit got=%h want=5a", value_B);
        end
        run_busy(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL busy_len_cen got=%0d want=32", n);
        end
    endtask

    task automatic test_overwrite;
        int n;
        cen = 1'b0;
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h11);
        wr(1'b1, 8'h22);
        n_cmp++;
        if (value_B !== 8'h5A) begin
            n_bad++;
            $display("FAIL ovw_early got=%h want=5a", value_B);
        end
        cen = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (value_B !== 8'h22) begin
            n_bad++;
            $display("FAIL ovw_value_B got=%h want=22", value_B);
        end
        run_busy(n);
        cen = 1'b0;
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h33);
        wr(1'b0, 8'h10);
        cen = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({value_A, value_B} !== {10'h2AF, 8'h33}) begin
            n_bad++;
            $display("FAIL addr_while_pend got=%h/%h want=2af/33",
                     value_A, value_B);
        end
        run_busy(n);
    endtask

    task automatic test_dout;
        int n;
        flag_A = 1'b1;
        flag_B = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dout !== 8'h01) begin
            n_bad++;
            $display("FAIL dout_idle got=%h want=01", dout);
        end
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (dout !== 8'h81) begin
            n_bad++;
            $display("FAIL dout_busy got=%h want=81", dout);
        end
        n_cmp++;
        if ({value_A, value_B} !== {10'h2AF, 8'h33}) begin
            n_bad++;
            $display("FAIL other_addr got=%h/%h want=2af/33",
                     value_A, value_B);
        end
        run_busy(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL busy_len_other got=%0d want=32", n);
        end
        @(negedge clk);
        n_cmp++;
        if (dout !== 8'h01) begin
            n_bad++;
            $display("FAIL dout_after got=%h want=01", dout);
        end
        flag_A = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        cen = 1'b0;
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h44);
        @(negedge clk);
        cen = 1'b1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h55;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        n_cmp++;
        if ({busy, value_B} !== {1'b1, 8'h44}) begin
            n_bad++;
            $display("FAIL b2b_first got=%b/%h want=1/44", busy, value_B);
        end
        @(negedge clk);
        n_cmp++;
        if (value_B !== 8'h55) begin
            n_bad++;
            $display("FAIL b2b_second got=%h want=55", value_B);
        end
        run_busy(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL busy_len_b2b got=%0d want=32", n);
        end
    endtask

    task automatic test_reset_mid;
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h00);
        @(negedge clk);
        repeat (12) @(negedge clk);
        cen = 1'b0;
        wr(1'b0, 8'h10);
        wr(1'b1, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out() !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_mid got=%h want=0", all_out());
        end
        @(negedge clk);
        rst_n = 1'b1;
        cen = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({busy, value_A} !== {1'b0, 10'h000}) begin
            n_bad++;
            $display("FAIL reset_no_commit got=%b/%h want=0/000",
                     busy, value_A);
        end
    endtask

    initial begin
        test_reset;
        test_value_a;
        test_ctrl;
        test_cen_low;
        test_overwrite;
        test_dout;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jt51_timer_mmr.md
JT51_TIMER_MMR -- requirements
Module: jt51_timer_mmr

Interface
REQ-001 SHALL have parameter: BUSY_CYCLES, 32, number of cen ticks busy stays high after a register commit (range 1..255).
REQ-002 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cen  in  1  clock enable for commit and busy counting.
REQ-005 SHALL have ports: cs_n, wr_n, a0  in  1 each  CPU chip select, write strobe (both active-low) and address bit.
REQ-006 SHALL have port: din  in  8  CPU write data.
REQ-007 SHALL have port: dout  out  8  status {busy, 5'b0, flag_B, flag_A}.
REQ-008 SHALL have ports: flag_A, flag_B  in  1 each  timer flags from the timer block.
REQ-009 SHALL have ports: value_A  out  10, value_B  out  8  timer start values.
REQ-010 SHALL have ports: load_A, load_B, enable_irq_A, enable_irq_B, csm  out  1 each  register 0x14 levels.
REQ-011 SHALL have ports: clr_flag_A, clr_flag_B  out  1 each  single-clk flag-clear pulses.
REQ-012 SHALL have port: busy  out  1  write in progress.

Function
REQ-013 Write event SHALL be the first clk with !cs_n && !wr_n after a clk without it (edge detect, one event per strobe).
REQ-014 Write event with a0=0 SHALL latch din into the address register; nothing else changes.
REQ-015 Write event with a0=1 SHALL capture the pair {address register, din} and set pending; pending overwrites any uncommitted pair.
REQ-016 On a clk with cen=1 and pending=1, the captured pair SHALL commit, pending SHALL clear, and busy_cnt SHALL load BUSY_CYCLES.
REQ-017 Commit map: 0x10 -> value_A[9:2]=din; 0x11 -> value_A[1:0]=din[1:0]; 0x12 -> value_B=din; 0x14 -> load_A=d0, load_B=d1, enable_irq_A=d2, enable_irq_B=d3, csm=d7; other addresses SHALL only restart busy.
REQ-018 Commit of 0x14 SHALL pulse clr_flag_A for one clk if d4=1 and clr_flag_B if d5=1; d4/d5 not stored.
REQ-019 busy_cnt SHALL decrement on each cen tick when non-zero and not committing; it SHALL saturate at 0.
REQ-020 busy SHALL equal pending || (busy_cnt != 0), combinational from registers.
REQ-021 dout SHALL be registered every clk from busy, flag_B, flag_A (one clk latency).
REQ-022 Data write event on the same clk as a commit SHALL be captured as a new pending pair; the older pair still commits.
REQ-023 Address write while pending SHALL not alter the already-captured pair.
REQ-024 Data write while busy_cnt!=0 SHALL be accepted and, on commit, restart busy_cnt at BUSY_CYCLES.

Reset
REQ-025 rst_n low SHALL asynchronously clear address, pending, busy_cnt, value_A, value_B, all 0x14 levels, clr pulses, edge-detect state and dout to 0.
REQ-026 Reset asserted mid-pending SHALL discard the pending pair; no commit after release.

Structure
REQ-027 Register addresses 0x10/0x11/0x12/0x14, 0x14 bit positions and BUSY_CYCLES default SHALL live in the shared jt51 package.
REQ-028 Block SHALL be flat except one sub-module jt51_busy_cnt (load/decrement/saturate counter, BUSY_CYCLES parameter).

Verification
REQ-029 Write a0=0 din=0x10, a0=1 din=0xAB, then 0x11/0x03 -> value_A=0x2AF after second commit; busy high BUSY_CYCLES cen ticks after each commit.
REQ-030 Write 0x14 data 0x35 -> load_A=1, load_B=0, enable_irq_A=1, clr_flag_A one-clk pulse, clr_flag_B one-clk pulse, csm=0.
REQ-031 cen held low 10 clks after data write -> pending and busy high, outputs unchanged until first cen.
REQ-032 Two data writes (0x12: 0x11, then 0x12: 0x22) before any cen -> only value_B=0x22 committed.
REQ-033 flag_A=1, flag_B=0, idle -> dout=0x01 one clk later; during busy dout=0x81.
REQ-034 rst_n pulsed low with pending set and busy_cnt=20 -> all outputs 0 immediately, no commit after release.
